// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared FSM state encoding and default sizing for the data-memory arbiter.
`default_nettype none

package dm_arb_pkg;

    localparam int DM_CORES  = 4;
    localparam int DM_ADDR_W = 32;
    localparam int DM_DATA_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dm_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting at last_i+1 modulo N.
`default_nettype none

module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] cand;

    // Walk from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = last_i;
        cand    = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(last_i) + k) % N);
            if (req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter sharing one data-memory port among CORES requesters.
// Optional bus lock enabled by defining DM_ARB_LOCK_EN.
`default_nettype none

module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int CORES  = DM_CORES,
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = DM_DATA_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CORES-1:0]           req,
    input  logic [CORES-1:0]           we,
    input  logic [CORES*ADDR_W-1:0]    addr,
    input  logic [CORES*DATA_W-1:0]    wdata,
`ifdef DM_ARB_LOCK_EN
    input  logic [CORES-1:0]           lock,
`endif
    output logic [CORES-1:0]           ack,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(CORES)-1:0]   grant_id,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int IW = $clog2(CORES);

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [CORES-1:0]  elig;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef DM_ARB_LOCK_EN
    logic held_q, held_d;

    // While held, only the previous owner (last_q) may win.
    assign elig = held_q ? (req & (CORES'(1) << last_q)) : req;
`else
    assign elig = req;
`endif

    rr_picker #(
        .N  (CORES),
        .IW (IW)
    ) u_picker (
        .req_i   (elig),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < CORES; i++) begin
            if (IW'(i) == pick_idx) begin
                sel_we    = we[i];
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef DM_ARB_LOCK_EN
        held_d  = held_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_ACCESS;
                    win_d   = pick_idx;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP: begin
                state_d = ST_IDLE;
                last_d  = win_q;
`ifdef DM_ARB_LOCK_EN
                held_d  = lock[win_q];
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= IW'(CORES - 1);
            win_q   <= IW'(CORES - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef DM_ARB_LOCK_EN
            held_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef DM_ARB_LOCK_EN
            held_q  <= held_d;
`endif
        end
    end

    // Outputs decode from registered state only, so reset clears them immediately.
    assign mem_en    = (state_q == ST_ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = mem_en ? addr_q : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;

    assign ack      = (state_q == ST_RESP) ? (CORES'(1) << win_q) : '0;
    assign rdata    = ((state_q == ST_RESP) && !we_q) ? mem_rdata : '0;
    assign grant_id = (state_q == ST_IDLE) ? last_q : win_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed self-checking bench for dm_arbiter with a small memory model.
`default_nettype none

module tb_dm_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   we;
    logic [127:0] addr;
    logic [127:0] wdata;
    logic [3:0]   lock;
    logic [3:0]   ack;
    logic [31:0]  rdata;
    logic [1:0]   grant_id;
    logic         mem_en;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;

    int checks = 0;
    int errors = 0;

    dm_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
`ifdef DM_ARB_LOCK_EN
        .lock      (lock),
`endif
        .ack       (ack),
        .rdata     (rdata),
        .grant_id  (grant_id),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory: mem[i] = i + 2 at start, so mem[5] = 7.
    logic [31:0] mem [16];
    bit          mem_init;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'(i + 2);
            mem_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[3:0]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[3:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag, input logic [3:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (ack == 4'b0 && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(ack), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        lock  = '0;
        mem_rdata = '0;
        #1 reset = 1'b1;
        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_gid", 32'(grant_id), 32'd3);
        req = 4'b1111;
        repeat (2) @(negedge clk);
        chk("rst_hold_mem_en", 32'(mem_en), 32'h0);
        chk("rst_hold_rdata", rdata, 32'h0);
        chk("rst_hold_gid", 32'(grant_id), 32'd3);
        reset = 1'b0;

        // Single read: core 2, addr 5
        req = 4'b0100; we = 4'b0000; addr[64 +: 32] = 32'd5;
        @(negedge clk);
        chk("rd_mem_en", 32'(mem_en), 32'h1);
        chk("rd_mem_we", 32'(mem_we), 32'h0);
        chk("rd_mem_addr", mem_addr, 32'd5);
        chk("rd_gid", 32'(grant_id), 32'd2);
        addr[64 +: 32] = 32'd9;
        @(negedge clk);
        chk("rd_ack", 32'(ack), 32'b0100);
        chk("rd_rdata", rdata, 32'd7);
        req = 4'b0000;
        @(negedge clk);
        chk("rd_ack_gone", 32'(ack), 32'h0);
        chk("rd_idle_gid", 32'(grant_id), 32'd2);

        // Single write: core 1 writes 9 to addr 3, then reads it back
        req = 4'b0010; we = 4'b0010; addr[32 +: 32] = 32'd3; wdata[32 +: 32] = 32'd9;
        @(negedge clk);
        chk("wr_mem_en", 32'(mem_en), 32'h1);
        chk("wr_mem_we", 32'(mem_we), 32'h1);
        chk("wr_mem_addr", mem_addr, 32'd3);
        chk("wr_mem_wdata", mem_wdata, 32'd9);
        @(negedge clk);
        chk("wr_ack", 32'(ack), 32'b0010);
        chk("wr_rdata_zero", rdata, 32'h0);
        req = 4'b0000;
        @(negedge clk);
        req = 4'b0010; we = 4'b0000;
        wait_ack("rb_ack", 4'b0010);
        chk("rb_rdata", rdata, 32'd9);
        req = 4'b0000;
        @(negedge clk);

        // Fairness after reset with all requests held
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        addr = '0; we = '0;
        req = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            wait_ack($sformatf("fair_%0d", k), 4'(1 << (k % 4)));
        end

        // Contention with last_grant = 3
        req = 4'b1001;
        wait_ack("cont_first", 4'b0001);
        wait_ack("cont_second", 4'b1000);
        req = 4'b0000;
        @(negedge clk);
        chk("cont_idle_gid", 32'(grant_id), 32'd3);
        chk("cont_idle_ack", 32'(ack), 32'h0);

        // Reset in ACCESS
        req = 4'b0100;
        @(negedge clk);
        chk("mid_mem_en_pre", 32'(mem_en), 32'h1);
        req = 4'b0000;
        #1 reset = 1'b1;
        #1;
        chk("mid_mem_en", 32'(mem_en), 32'h0);
        chk("mid_gid", 32'(grant_id), 32'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_no_ack", 32'(ack), 32'h0);
        end
        reset = 1'b0;
        req = 4'b0101;
        wait_ack("mid_next_core0", 4'b0001);

`ifdef DM_ARB_LOCK_EN
        // Core 1 locks for three accesses while core 2 waits
        req = 4'b0110; lock = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            wait_ack($sformatf("lock_held_%0d", k), 4'b0010);
        end
        lock = 4'b0000;
        wait_ack("lock_release", 4'b0010);
        wait_ack("lock_core2", 4'b0100);
`endif
        req = 4'b0000;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
